// File: rtl/io_irq_bridge.sv
// Peripheral-side processor I/O bridge: prioritised IRQ pulse generator, input word FIFO, output capture register.
// Define IRQ_SYNC_EN to pass ext_irq through a two-flop synchronizer before edge detection.
module io_irq_bridge #(
  parameter int DATA_W       = 16,
  parameter int NUM_IRQ      = 4,
  parameter int IN_DEPTH     = 4,
  parameter int IRQ_PULSE    = 2,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_IRQ-1:0]         ext_irq,
  output logic                       interrupt_signal,
  output logic [$clog2(NUM_IRQ)-1:0] irq_id,
  input  logic                       ext_in_valid,
  input  logic [DATA_W-1:0]          ext_in_data,
  output logic                       ext_in_ready,
  output logic [DATA_W-1:0]          input_port,
  input  logic                       in_pop,
  output logic                       in_empty,
  input  logic [DATA_W-1:0]          out_port,
  input  logic                       out_wr,
  output logic [DATA_W-1:0]          ext_out_data,
  output logic                       ext_out_valid,
  input  logic                       ext_out_ready,
  output logic                       out_overrun,
  input  logic                       ovr_clr
);

  localparam int ID_W    = $clog2(NUM_IRQ);
  localparam int CNT_MAX = (IRQ_PULSE > GUARD_CYCLES) ? IRQ_PULSE : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PTR_W   = $clog2(IN_DEPTH);
  localparam int FCNT_W  = $clog2(IN_DEPTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ASSERT = 2'd1;
  localparam logic [1:0] GUARD  = 2'd2;

  logic [NUM_IRQ-1:0] irq_c;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ext_irq;
      sync2_q <= sync1_q;
    end
  end
  assign irq_c = sync2_q;
`else
  assign irq_c = ext_irq;
`endif

  // ---------------- interrupt request path ----------------
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d, pending_q, pending_d, clr, rise;
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d, pick;
  logic               int_sig_q, int_sig_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    irq_id_d   = irq_id_q;
    clr        = '0;
    pick       = '0;
    irq_prev_d = irq_c;
    rise       = irq_c & ~irq_prev_q;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending_q[i]) pick = ID_W'(i);
    end
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d     = ASSERT;
          irq_id_d    = pick;
          clr[pick]   = 1'b1;
          cnt_d       = CNT_W'(IRQ_PULSE - 1);
        end
      end
      ASSERT: begin
        if (cnt_q == '0) begin
          state_d = GUARD;
          cnt_d   = CNT_W'(GUARD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GUARD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge on the line being granted keeps it pending.
    pending_d = (pending_q & ~clr) | rise;
    int_sig_d = (state_d == ASSERT);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      irq_id_q   <= '0;
      int_sig_q  <= 1'b0;
    end else begin
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      irq_id_q   <= irq_id_d;
      int_sig_q  <= int_sig_d;
    end
  end

  assign interrupt_signal = int_sig_q;
  assign irq_id           = irq_id_q;

  // ---------------- input FIFO ----------------
  logic [DATA_W-1:0] mem_q [IN_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  logic              push, pop, full, empty;

  always_comb begin
    full     = (count_q == FCNT_W'(IN_DEPTH));
    empty    = (count_q == '0);
    push     = ext_in_valid & ~full;
    pop      = in_pop & ~empty;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the zero count already marks every entry invalid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ext_in_data;
  end

  assign ext_in_ready = ~full;
  assign in_empty     = empty;
  assign input_port   = empty ? '0 : mem_q[rd_ptr_q];

  // ---------------- output capture ----------------
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d, ovr_q, ovr_d;

  always_comb begin
    out_data_d  = out_wr ? out_port : out_data_q;
    out_valid_d = out_wr | (out_valid_q & ~ext_out_ready);
    // Overwriting an unaccepted word outranks a simultaneous clear.
    if (out_wr && out_valid_q && !ext_out_ready) ovr_d = 1'b1;
    else if (ovr_clr)                            ovr_d = 1'b0;
    else                                         ovr_d = ovr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovr_q       <= ovr_d;
    end
  end

  assign ext_out_data  = out_data_q;
  assign ext_out_valid = out_valid_q;
  assign out_overrun   = ovr_q;

endmodule

// File: tb/tb_io_irq_bridge.sv
// Directed self-checking bench for io_irq_bridge; inputs change and outputs are sampled 1ns after each rising edge.
module tb_io_irq_bridge;

`ifdef IRQ_SYNC_EN
  localparam int FIRST = 4;
`else
  localparam int FIRST = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ext_irq;
  logic        interrupt_signal;
  logic [1:0]  irq_id;
  logic        ext_in_valid;
  logic [15:0] ext_in_data;
  logic        ext_in_ready;
  logic [15:0] input_port;
  logic        in_pop;
  logic        in_empty;
  logic [15:0] out_port;
  logic        out_wr;
  logic [15:0] ext_out_data;
  logic        ext_out_valid;
  logic        ext_out_ready;
  logic        out_overrun;
  logic        ovr_clr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  io_irq_bridge dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq),
    .interrupt_signal(interrupt_signal), .irq_id(irq_id),
    .ext_in_valid(ext_in_valid), .ext_in_data(ext_in_data), .ext_in_ready(ext_in_ready),
    .input_port(input_port), .in_pop(in_pop), .in_empty(in_empty),
    .out_port(out_port), .out_wr(out_wr), .ext_out_data(ext_out_data),
    .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
    .out_overrun(out_overrun), .ovr_clr(ovr_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; ext_irq = '0; ext_in_valid = 1'b0; ext_in_data = '0; in_pop = 1'b0;
    out_port = '0; out_wr = 1'b0; ext_out_ready = 1'b0; ovr_clr = 1'b0;
    #1;
    check("rst_int", interrupt_signal, 0);
    check("rst_id", irq_id, 0);
    check("rst_empty", in_empty, 1);
    check("rst_ready", ext_in_ready, 1);
    check("rst_inport", input_port, 0);
    check("rst_ovalid", ext_out_valid, 0);
    check("rst_odata", ext_out_data, 0);
    check("rst_ovr", out_overrun, 0);
    #11 rst = 1'b1;
    tick(); tick();

    // Two lines rise together: id 1 first, then id 2 after the guard and idle cycles.
    ext_irq = 4'b0110;
    for (int e = 1; e <= FIRST + 13; e++) begin
      tick();
      check("prio_int", interrupt_signal,
            (e == FIRST || e == FIRST + 1 || e == FIRST + 7 || e == FIRST + 8) ? 1 : 0);
      check("prio_id", irq_id, (e < FIRST) ? 0 : (e < FIRST + 7) ? 1 : 2);
    end
    ext_irq = '0;
    tick(); tick();

    // Single line latency.
    ext_irq = 4'b1000;
    for (int e = 1; e <= FIRST; e++) begin
      tick();
      check("lat_int", interrupt_signal, (e == FIRST) ? 1 : 0);
    end
    check("lat_id", irq_id, 3);
    ext_irq = '0;
    repeat (8) tick();
    check("lat_done", interrupt_signal, 0);

    // FIFO fill, full push+pop, drain, empty-pop, push+pop in non-full state.
    for (int i = 1; i <= 4; i++) begin
      ext_in_valid = 1'b1; ext_in_data = 16'(i);
      tick();
      check("fill_head", input_port, 1);
      check("fill_empty", in_empty, 0);
    end
    check("full_ready", ext_in_ready, 0);
    ext_in_data = 16'h0005; in_pop = 1'b1;
    tick();
    check("fullpp_head", input_port, 16'h0002);
    check("fullpp_ready", ext_in_ready, 1);
    ext_in_valid = 1'b0;
    tick(); check("pop_head3", input_port, 16'h0003);
    tick(); check("pop_head4", input_port, 16'h0004);
    tick(); check("pop_empty", in_empty, 1);
    check("pop_zero", input_port, 0);
    tick(); check("pop_on_empty", in_empty, 1);
    ext_in_valid = 1'b1; ext_in_data = 16'h0055;
    tick();
    check("empty_pp_head", input_port, 16'h0055);
    ext_in_data = 16'h0066;
    tick();
    check("pp_head", input_port, 16'h0066);
    ext_in_valid = 1'b0;
    tick();
    check("pp_count1", in_empty, 1);
    in_pop = 1'b0;

    // Output capture and overrun.
    out_port = 16'h00AA; out_wr = 1'b1; ext_out_ready = 1'b0;
    tick();
    check("cap_valid", ext_out_valid, 1);
    check("cap_data", ext_out_data, 16'h00AA);
    check("cap_ovr0", out_overrun, 0);
    out_port = 16'h00BB;
    tick();
    out_wr = 1'b0;
    check("ovr_data", ext_out_data, 16'h00BB);
    check("ovr_set", out_overrun, 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr", out_overrun, 0);
    check("ovr_valid_held", ext_out_valid, 1);
    ext_out_ready = 1'b1;
    tick();
    check("hs_clear", ext_out_valid, 0);
    ext_out_ready = 1'b0; out_port = 16'h0022; out_wr = 1'b1;
    tick();
    out_port = 16'h0011; ext_out_ready = 1'b1;
    tick();
    out_wr = 1'b0;
    check("hswr_valid", ext_out_valid, 1);
    check("hswr_data", ext_out_data, 16'h0011);
    check("hswr_ovr", out_overrun, 0);
    ext_out_ready = 1'b0; out_port = 16'h0033; out_wr = 1'b1; ovr_clr = 1'b1;
    tick();
    out_wr = 1'b0; ovr_clr = 1'b0;
    check("ovr_beats_clr", out_overrun, 1);

    // Mid-pulse reset with two FIFO words and a pending capture.
    ext_in_valid = 1'b1; ext_in_data = 16'h00A1; tick();
    ext_in_data = 16'h00A2; tick();
    ext_in_valid = 1'b0;
    check("pre_rst_head", input_port, 16'h00A1);
    ext_irq = 4'b0001;
    for (int k = 0; k < 10 && interrupt_signal !== 1'b1; k++) tick();
    check("pre_rst_pulse", interrupt_signal, 1);
    rst = 1'b0; ext_irq = '0;
    #1;
    check("mrst_int", interrupt_signal, 0);
    check("mrst_id", irq_id, 0);
    check("mrst_empty", in_empty, 1);
    check("mrst_ready", ext_in_ready, 1);
    check("mrst_inport", input_port, 0);
    check("mrst_ovalid", ext_out_valid, 0);
    check("mrst_odata", ext_out_data, 0);
    check("mrst_ovr", out_overrun, 0);
    #2 rst = 1'b1;
    repeat (3) tick();
    check("post_rst_int", interrupt_signal, 0);
    check("post_rst_empty", in_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
